rf_write_buffer: RTL and testbench
==================================

// Module: rf_write_buffer
// PURPOSE
//  Write-request buffer sitting directly upstream of the 8x8b 1r1w register file's write port.
//  Accepts write requests (addr,data) on a val/rdy interface and queues them in order in a
//  DEPTH-entry circular FIFO. Drains at most one entry per cycle onto the RF write port.
//  Offers a bypass lookup so readers see the youngest still-pending write to an address.
// PARAMETERS
//  DEPTH   4  number of queue entries (power of two, >=2)
//  AWIDTH  3  register address width
//  DWIDTH  8  register data width
// PORTS
//  clk            in   1          clock, all state updates on rising edge
//  reset          in   1          asynchronous, active-high reset
//  enq_val        in   1          write request valid
//  enq_rdy        out  1          buffer can accept a request this cycle
//  enq_addr       in   AWIDTH     request register address
//  enq_data       in   DWIDTH     request write data
//  drain_stall    in   1          1 = hold drain this cycle (RF write port borrowed)
//  rf_write_en    out  1          drives RF write_en
//  rf_write_addr  out  AWIDTH     drives RF write_addr
//  rf_write_data  out  DWIDTH     drives RF write_data
//  lookup_addr    in   AWIDTH     bypass query address
//  lookup_hit     out  1          a pending entry matches lookup_addr
//  lookup_data    out  DWIDTH     data of youngest matching pending entry
//  count          out  $clog2(DEPTH)+1  number of pending entries
// BEHAVIOUR
//  - State: head ptr, tail ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count (0..DEPTH), entry array.
//  - Reset (async, immediate): head=tail=count=0; hence enq_rdy=1, rf_write_en=0,
//    rf_write_addr=0, rf_write_data=0, lookup_hit=0, lookup_data=0. Entry array not reset.
//  - Reset mid-operation discards all pending writes; none reach the RF afterwards.
//  - enq_rdy = (count != DEPTH); from registered state only, no dependence on same-cycle drain.
//  - enq fire = enq_val & enq_rdy: entry[tail] <= {enq_addr,enq_data}, tail++ at edge.
//  - enq_val while full is ignored (request dropped by the handshake, no state change).
//  - rf_write_en = (count != 0) & !drain_stall, combinational from state.
//  - rf_write_addr/data = entry[head] when rf_write_en=1, else 0. drain fire: head++ at edge.
//  - Minimum latency enq -> rf_write_en: 1 cycle (no enq-to-RF combinational path).
//  - Simultaneous enq fire and drain fire: count unchanged, both pointers advance.
//  - Drain order strictly FIFO; duplicate addresses are NOT coalesced.
//  - Lookup (combinational): search the count valid entries from head; if any addr matches,
//    lookup_hit=1, lookup_data=youngest (closest to tail) match; else hit=0, data=0.
//  - Entry draining this cycle still counts for lookup; same-cycle enq is NOT visible.
//  - count arithmetic: +1 on enq-only, -1 on drain-only, never wraps (guarded by rdy/empty).
// STRUCTURE
//  - Package rf_wb_pkg: localparams AWIDTH, DWIDTH; typedef struct packed {addr; data} wr_req_t.
//  - Sub-module rf_wb_lookup: combinational youngest-match search over DEPTH entries given
//    head and count; everything else (pointers, count, storage) in the top module.
// TESTING
//  1 Reset, idle -> enq_rdy=1, rf_write_en=0, count=0, lookup_hit=0, lookup_data=0.
//  2 enq (3,0xab) one cycle, no stall -> next cycle rf_write_en=1 addr=3 data=0xab;
//    cycle after: count=0, rf_write_en=0.
//  3 drain_stall=1; enq (0,01),(1,23),(0,45),(2,67) -> count=4, enq_rdy=0; 5th enq (7,ff)
//    dropped; lookup 0 -> hit=1 data=0x45; lookup 5 -> hit=0 data=0.
//  4 Release stall -> rf_write_en 4 consecutive cycles: 0/01,1/23,0/45,2/67; with enq of
//    (6,cd) while count=2 -> count stays 2, (6,cd) drains after 2/67.
//  5 Assert reset between edges while count=3 -> rf_write_en=0 and count=0 immediately;
//    after release no writes issue until new enq.
//  6 Random 200 cycles (random enq/stall/lookup) vs golden queue+RF model ->
//    rf_write_* stream, lookup_hit/data, count and final RF contents all match.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared widths and the queued write-request record for the register-file write buffer.
package rf_wb_pkg;

    localparam int AWIDTH = 3;
    localparam int DWIDTH = 8;

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rf_wb_lookup.sv
// Youngest-match bypass search over the pending window [head, head+count) of the write queue.
module rf_wb_lookup
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  wr_req_t [DEPTH-1:0] entries,
    input  logic [PW-1:0]       head,
    input  logic [CW-1:0]       count,
    input  logic [AWIDTH-1:0]   lookup_addr,
    output logic                hit,
    output logic [DWIDTH-1:0]   data
);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (entries[idx].addr == lookup_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/rf_write_buffer.sv
// In-order write-request FIFO feeding the register-file write port, with bypass lookup.
module rf_write_buffer
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq_val,
    output logic              enq_rdy,
    input  logic [AWIDTH-1:0] enq_addr,
    input  logic [DWIDTH-1:0] enq_data,
    input  logic              drain_stall,
    output logic              rf_write_en,
    output logic [AWIDTH-1:0] rf_write_addr,
    output logic [DWIDTH-1:0] rf_write_data,
    input  logic [AWIDTH-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [DWIDTH-1:0] lookup_data,
    output logic [CW-1:0]     count
);

    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    wr_req_t [DEPTH-1:0]  entries_q, entries_d;
    logic                 enq_fire;
    logic                 drain_fire;

    // Ready and drain depend only on registered state, so no enq-to-RF path exists.
    assign enq_rdy     = (count_q != CW'(DEPTH));
    assign rf_write_en = (count_q != '0) && !drain_stall;
    assign enq_fire    = enq_val && enq_rdy;
    assign drain_fire  = rf_write_en;
    assign count       = count_q;

    assign rf_write_addr = rf_write_en ? entries_q[head_q].addr : '0;
    assign rf_write_data = rf_write_en ? entries_q[head_q].data : '0;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        entries_d = entries_q;
        if (enq_fire) begin
            entries_d[tail_q] = '{addr: enq_addr, data: enq_data};
            tail_d            = tail_q + PW'(1);
        end
        if (drain_fire) begin
            head_d = head_q + PW'(1);
        end
        case ({enq_fire, drain_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is only meaningful inside the count window, so it needs no reset.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    rf_wb_lookup #(.DEPTH(DEPTH)) u_lookup (
        .entries     (entries_q),
        .head        (head_q),
        .count       (count_q),
        .lookup_addr (lookup_addr),
        .hit         (lookup_hit),
        .data        (lookup_data)
    );

endmodule

// File: tb/tb_rf_write_buffer.sv
// Directed and randomized checks of rf_write_buffer against a queue-based reference model.
module tb_rf_write_buffer;
    import rf_wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              enq_val;
    logic              enq_rdy;
    logic [AWIDTH-1:0] enq_addr;
    logic [DWIDTH-1:0] enq_data;
    logic              drain_stall;
    logic              rf_write_en;
    logic [AWIDTH-1:0] rf_write_addr;
    logic [DWIDTH-1:0] rf_write_data;
    logic [AWIDTH-1:0] lookup_addr;
    logic              lookup_hit;
    logic [DWIDTH-1:0] lookup_data;
    logic [CW-1:0]     count;

    int tests = 0;
    int fails = 0;

    rf_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .enq_val       (enq_val),
        .enq_rdy       (enq_rdy),
        .enq_addr      (enq_addr),
        .enq_data      (enq_data),
        .drain_stall   (drain_stall),
        .rf_write_en   (rf_write_en),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .lookup_addr   (lookup_addr),
        .lookup_hit    (lookup_hit),
        .lookup_data   (lookup_data),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d);
        enq_val  = v;
        enq_addr = a;
        enq_data = d;
    endtask

    wr_req_t           mq[$];
    logic [DWIDTH-1:0] mrf[8];
    logic [DWIDTH-1:0] drf[8];
    logic [AWIDTH-1:0] exp_wa[5];
    logic [DWIDTH-1:0] exp_wd[5];
    logic [CW-1:0]     exp_cnt[5];

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, '0);
        drain_stall = 1'b0;
        lookup_addr = '0;
        #12;
        reset = 1'b0;
        #1;

        // Idle after reset
        chk("rst_rdy", enq_rdy, 1);
        chk("rst_en", rf_write_en, 0);
        chk("rst_count", count, 0);
        chk("rst_hit", lookup_hit, 0);
        chk("rst_ldata", lookup_data, 0);
        chk("rst_waddr", rf_write_addr, 0);
        chk("rst_wdata", rf_write_data, 0);

        // Single enqueue, one-cycle latency
        drive(1'b1, 3'd3, 8'hab);
        #1;
        chk("lat_en_same_cycle", rf_write_en, 0);
        next_cycle();
        drive(1'b0, '0, '0);
        #1;
        chk("single_en", rf_write_en, 1);
        chk("single_addr", rf_write_addr, 3);
        chk("single_data", rf_write_data, 8'hab);
        chk("single_count", count, 1);
        next_cycle();
        chk("single_after_count", count, 0);
        chk("single_after_en", rf_write_en, 0);

        // Fill while stalled, then try one more
        drain_stall = 1'b1;
        exp_wa = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd6};
        exp_wd = '{8'h01, 8'h23, 8'h45, 8'h67, 8'hcd};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, exp_wa[i], exp_wd[i]);
            #1;
            chk("fill_rdy", enq_rdy, 1);
            chk("fill_stalled_en", rf_write_en, 0);
            next_cycle();
        end
        drive(1'b1, 3'd7, 8'hff);
        #1;
        chk("full_count", count, 4);
        chk("full_rdy", enq_rdy, 0);
        next_cycle();
        drive(1'b0, '0, '0);
        #1;
        chk("drop_count", count, 4);
        lookup_addr = 3'd0;
        #1;
        chk("lk0_hit", lookup_hit, 1);
        chk("lk0_data", lookup_data, 8'h45);
        lookup_addr = 3'd5;
        #1;
        chk("lk5_hit", lookup_hit, 0);
        chk("lk5_data", lookup_data, 0);

        // Drain in order, with a concurrent enqueue at count=2
        drain_stall = 1'b0;
        exp_cnt = '{3'd4, 3'd3, 3'd2, 3'd2, 3'd1};
        for (int k = 0; k < 5; k++) begin
            if (k == 2) drive(1'b1, 3'd6, 8'hcd);
            else        drive(1'b0, '0, '0);
            #1;
            chk("drain_en", rf_write_en, 1);
            chk("drain_addr", rf_write_addr, exp_wa[k]);
            chk("drain_data", rf_write_data, exp_wd[k]);
            chk("drain_count", count, exp_cnt[k]);
            next_cycle();
        end
        drive(1'b0, '0, '0);
        #1;
        chk("drain_done_en", rf_write_en, 0);
        chk("drain_done_count", count, 0);

        // Asynchronous reset between edges discards pending writes
        drain_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, AWIDTH'(i + 4), DWIDTH'(8'h90 + i));
            next_cycle();
        end
        drive(1'b0, '0, '0);
        drain_stall = 1'b0;
        lookup_addr = 3'd4;
        #1;
        chk("prerst_count", count, 3);
        chk("prerst_en", rf_write_en, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_en", rf_write_en, 0);
        chk("async_rst_count", count, 0);
        chk("async_rst_hit", lookup_hit, 0);
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_idle_en", rf_write_en, 0);
            next_cycle();
        end

        // Randomized run against the reference model
        for (int r = 0; r < 8; r++) begin
            mrf[r] = '0;
            drf[r] = '0;
        end
        mq.delete();
        for (int c = 0; c < 200; c++) begin
            logic              e_rdy, e_en, e_hit;
            logic [AWIDTH-1:0] e_wa;
            logic [DWIDTH-1:0] e_wd, e_ld;
            drive($urandom_range(0, 99) < 60, AWIDTH'($urandom_range(0, 7)), DWIDTH'($urandom));
            drain_stall = ($urandom_range(0, 99) < 30);
            lookup_addr = AWIDTH'($urandom_range(0, 7));
            #1;
            e_rdy = (mq.size() != DEPTH);
            e_en  = (mq.size() != 0) && !drain_stall;
            e_wa  = e_en ? mq[0].addr : '0;
            e_wd  = e_en ? mq[0].data : '0;
            e_hit = 1'b0;
            e_ld  = '0;
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].addr == lookup_addr) begin
                    e_hit = 1'b1;
                    e_ld  = mq[i].data;
                    break;
                end
            end
            chk("rnd_rdy", enq_rdy, e_rdy);
            chk("rnd_en", rf_write_en, e_en);
            chk("rnd_waddr", rf_write_addr, e_wa);
            chk("rnd_wdata", rf_write_data, e_wd);
            chk("rnd_hit", lookup_hit, e_hit);
            chk("rnd_ldata", lookup_data, e_ld);
            chk("rnd_count", count, mq.size());
            if (rf_write_en) drf[rf_write_addr] = rf_write_data;
            if (e_en) begin
                mrf[mq[0].addr] = mq[0].data;
                void'(mq.pop_front());
            end
            if (enq_val && e_rdy) mq.push_back('{addr: enq_addr, data: enq_data});
            next_cycle();
        end
        for (int r = 0; r < 8; r++) begin
            chk("final_rf", drf[r], mrf[r]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
